// File: rtl/timer_alarm_scheduler_pkg.sv
// Shared definitions for the alarm scheduler: register offsets, FSM state
// encodings and the per-channel record.
package timer_alarm_scheduler_pkg;

   // Per-channel word offsets within a 4-word channel window.
   localparam logic [1:0] OFF_DEADLINE_L = 2'd0;
   localparam logic [1:0] OFF_DEADLINE_H = 2'd1;
   localparam logic [1:0] OFF_CTRL       = 2'd2;
   localparam logic [1:0] OFF_PERIOD     = 2'd3;

   // Global word offsets relative to 4*NUM_CH.
   localparam int unsigned OFF_PENDING = 0;
   localparam int unsigned OFF_MASK    = 1;
   localparam int unsigned OFF_STATUS  = 2;

   // Scan/compare FSM states.
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SCAN  = 2'd1;
   localparam logic [1:0] ST_ARMED = 2'd2;

   // One alarm channel.
   typedef struct packed {
      logic [63:0] deadline;
      logic        en;
      logic [31:0] period;
   } chan_t;

endpackage

// File: rtl/timer_alarm_scheduler_min_scan.sv
// Earliest-deadline search datapath: walks the channels one per cycle and
// keeps the lowest enabled deadline (ties resolved to the lowest index).
// Ports:
//   hb_clk, hb_rst_n  clock and async active-low reset
//   clr               restart the walk at index 0 with no best
//   step              evaluate the candidate at idx this cycle
//   cand_deadline/en  deadline and enable of channel idx
//   idx               channel currently being evaluated
//   best_*            current best (held while armed)
//   done_c            last channel is being evaluated this cycle
//   found_c           a best exists including this cycle's candidate
module timer_alarm_scheduler_min_scan #(
   parameter  int unsigned NUM_CH = 4,
   localparam int unsigned IDX_W  = $clog2(NUM_CH)
) (
   input  logic             hb_clk,
   input  logic             hb_rst_n,
   input  logic             clr,
   input  logic             step,
   input  logic [63:0]      cand_deadline,
   input  logic             cand_en,
   output logic [IDX_W-1:0] idx,
   output logic [IDX_W-1:0] best_idx,
   output logic [63:0]      best_deadline,
   output logic             best_valid,
   output logic             done_c,
   output logic             found_c
);

   logic last_c;
   logic take_c;

   // Strict less-than keeps the earlier (lower) index on equal deadlines.
   assign last_c  = (idx == IDX_W'(NUM_CH - 1));
   assign take_c  = step && cand_en && (!best_valid || (cand_deadline < best_deadline));
   assign done_c  = step && last_c;
   assign found_c = best_valid || take_c;

   // Walk/best registers.
   always_ff @(posedge hb_clk or negedge hb_rst_n) begin
      if (!hb_rst_n) begin
         idx           <= '0;
         best_idx      <= '0;
         best_deadline <= '0;
         best_valid    <= 1'b0;
      end else if (clr) begin
         idx           <= '0;
         best_idx      <= '0;
         best_deadline <= '0;
         best_valid    <= 1'b0;
      end else if (step) begin
         if (take_c) begin
            best_valid    <= 1'b1;
            best_idx      <= idx;
            best_deadline <= cand_deadline;
         end
         idx <= last_c ? '0 : idx + IDX_W'(1);
      end
   end

endmodule

// File: rtl/timer_alarm_scheduler.sv
// Alarm scheduler: NUM_CH software alarms multiplexed onto the 64-bit mtime.
// Holds the register file and the IDLE/SCAN/ARMED FSM; the earliest-deadline
// search lives in timer_alarm_scheduler_min_scan.
// Build option: define ALARM_PERIODIC_EN to add the per-channel period
// register (auto-reload on fire); otherwise all channels are one-shot.
// Ports:
//   hb_clk, hb_rst_n  bus clock, async active-low reset
//   mtime             machine time from the system timer
//   waddr/wdata/wen   word write port
//   raddr/ren         word read port; rdata registered, 1-cycle latency
//   alarm_int         registered |(pending & mask)
//   alarm_pending     raw pending bits
module timer_alarm_scheduler
   import timer_alarm_scheduler_pkg::*;
#(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned ADDR_W = 5
) (
   input  logic              hb_clk,
   input  logic              hb_rst_n,
   input  logic [63:0]       mtime,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [31:0]       wdata,
   input  logic              wen,
   input  logic [ADDR_W-1:0] raddr,
   input  logic              ren,
   output logic [31:0]       rdata,
   output logic              alarm_int,
   output logic [NUM_CH-1:0] alarm_pending
);

   localparam int unsigned IDX_W    = $clog2(NUM_CH);
   localparam int unsigned CH_WORDS = 4 * NUM_CH;

   chan_t             chan_q [NUM_CH];
   chan_t             chan_d [NUM_CH];
   logic [NUM_CH-1:0] pending_q, pending_d;
   logic [NUM_CH-1:0] mask_q, mask_d;
   logic [1:0]        state_q, state_d;
   logic [NUM_CH-1:0] en_vec_c;

   logic              w_ch_c, w_pend_c, w_mask_c, w_restart_c;
   logic [IDX_W-1:0]  w_idx_c;
   logic [1:0]        w_off_c;
   logic              r_ch_c;
   logic [IDX_W-1:0]  r_idx_c;
   logic [31:0]       rd_c;

   logic              fire_c, scan_clr_c, scan_step_c, busy_c;
   logic [IDX_W-1:0]  scan_idx;
   logic [IDX_W-1:0]  best_idx;
   logic [63:0]       best_deadline;
   logic              best_valid;
   logic              scan_done_c, scan_found_c;

   // Write decode.
   assign w_ch_c   = wen && (32'(waddr) < CH_WORDS);
   assign w_idx_c  = IDX_W'(waddr >> 2);
   assign w_off_c  = waddr[1:0];
   assign w_pend_c = wen && (32'(waddr) == CH_WORDS + OFF_PENDING);
   assign w_mask_c = wen && (32'(waddr) == CH_WORDS + OFF_MASK);
`ifdef ALARM_PERIODIC_EN
   assign w_restart_c = w_ch_c;
`else
   // The period slot is unmapped in this build, so writing it changes nothing.
   assign w_restart_c = w_ch_c && (w_off_c != OFF_PERIOD);
`endif

   // Read decode.
   assign r_ch_c  = 32'(raddr) < CH_WORDS;
   assign r_idx_c = IDX_W'(raddr >> 2);

   // Enable vector for the IDLE wake-up.
   always_comb begin
      en_vec_c = '0;
      for (int c = 0; c < NUM_CH; c++) en_vec_c[c] = chan_q[c].en;
   end

   // FSM next state and fire decision.
   always_comb begin
      state_d = state_q;
      fire_c  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (w_restart_c || (|en_vec_c)) state_d = ST_SCAN;
         end
         ST_SCAN: begin
            if (w_restart_c)      state_d = ST_SCAN;
            else if (scan_done_c) state_d = scan_found_c ? ST_ARMED : ST_IDLE;
         end
         ST_ARMED: begin
            fire_c = (mtime >= best_deadline);
            if (fire_c || w_restart_c) state_d = ST_SCAN;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // A scan walk starts fresh on entry to SCAN or on a config write mid-walk.
   assign scan_clr_c  = (state_d == ST_SCAN) && ((state_q != ST_SCAN) || w_restart_c);
   assign scan_step_c = (state_q == ST_SCAN) && !w_restart_c;
   assign busy_c      = (state_q == ST_SCAN);

   timer_alarm_scheduler_min_scan #(
      .NUM_CH (NUM_CH)
   ) u_alarm_min_scan (
      .hb_clk        (hb_clk),
      .hb_rst_n      (hb_rst_n),
      .clr           (scan_clr_c),
      .step          (scan_step_c),
      .cand_deadline (chan_q[scan_idx].deadline),
      .cand_en       (chan_q[scan_idx].en),
      .idx           (scan_idx),
      .best_idx      (best_idx),
      .best_deadline (best_deadline),
      .best_valid    (best_valid),
      .done_c        (scan_done_c),
      .found_c       (scan_found_c)
   );

   // Register file next state; the fire is applied after bus writes so it
   // wins on pending (over W1C) and on the fired channel's enable/deadline.
   always_comb begin
      chan_d    = chan_q;
      pending_d = pending_q;
      mask_d    = mask_q;
      if (w_ch_c) begin
         case (w_off_c)
            OFF_DEADLINE_L: chan_d[w_idx_c].deadline[31:0]  = wdata;
            OFF_DEADLINE_H: chan_d[w_idx_c].deadline[63:32] = wdata;
            OFF_CTRL:       chan_d[w_idx_c].en              = wdata[0];
`ifdef ALARM_PERIODIC_EN
            OFF_PERIOD:     chan_d[w_idx_c].period          = wdata;
`endif
            default: ;
         endcase
      end
      if (w_pend_c) pending_d = pending_q & ~wdata[NUM_CH-1:0];
      if (w_mask_c) mask_d    = wdata[NUM_CH-1:0];
      if (fire_c) begin
         pending_d[best_idx] = 1'b1;
`ifdef ALARM_PERIODIC_EN
         if (chan_q[best_idx].period != '0)
            chan_d[best_idx].deadline = chan_q[best_idx].deadline
                                        + 64'(chan_q[best_idx].period);
         else
            chan_d[best_idx].en = 1'b0;
`else
         chan_d[best_idx].en = 1'b0;
`endif
      end
`ifndef ALARM_PERIODIC_EN
      // Period field is tied to zero and optimises away in this build.
      for (int c = 0; c < NUM_CH; c++) chan_d[c].period = '0;
`endif
   end

   // Read mux.
   always_comb begin
      rd_c = '0;
      if (r_ch_c) begin
         case (raddr[1:0])
            OFF_DEADLINE_L: rd_c = chan_q[r_idx_c].deadline[31:0];
            OFF_DEADLINE_H: rd_c = chan_q[r_idx_c].deadline[63:32];
            OFF_CTRL:       rd_c = 32'(chan_q[r_idx_c].en);
            default:        rd_c = chan_q[r_idx_c].period;
         endcase
      end else if (32'(raddr) == CH_WORDS + OFF_PENDING) begin
         rd_c = 32'(pending_q);
      end else if (32'(raddr) == CH_WORDS + OFF_MASK) begin
         rd_c = 32'(mask_q);
      end else if (32'(raddr) == CH_WORDS + OFF_STATUS) begin
         rd_c = {23'd0, busy_c, 1'b0, 3'(best_idx), 3'd0, best_valid};
      end
   end

   // State, registers and outputs.
   always_ff @(posedge hb_clk or negedge hb_rst_n) begin
      if (!hb_rst_n) begin
         state_q   <= ST_IDLE;
         for (int c = 0; c < NUM_CH; c++) chan_q[c] <= '0;
         pending_q <= '0;
         mask_q    <= '0;
         rdata     <= '0;
         alarm_int <= 1'b0;
      end else begin
         state_q   <= state_d;
         chan_q    <= chan_d;
         pending_q <= pending_d;
         mask_q    <= mask_d;
         if (ren) rdata <= rd_c;
         alarm_int <= |(pending_q & mask_q);
      end
   end

   assign alarm_pending = pending_q;

endmodule

// File: tb/tb_timer_alarm_scheduler.sv
// Directed bench for timer_alarm_scheduler (NUM_CH=4, ADDR_W=5).
module tb_timer_alarm_scheduler;

   localparam int unsigned NUM_CH = 4;
   localparam int unsigned ADDR_W = 5;
   localparam int unsigned A_PEND = 16;
   localparam int unsigned A_MASK = 17;
   localparam int unsigned A_STAT = 18;

   logic              hb_clk = 1'b0;
   logic              hb_rst_n;
   logic [63:0]       mtime;
   logic [ADDR_W-1:0] waddr;
   logic [31:0]       wdata;
   logic              wen;
   logic [ADDR_W-1:0] raddr;
   logic              ren;
   logic [31:0]       rdata;
   logic              alarm_int;
   logic [NUM_CH-1:0] alarm_pending;

   int errors = 0;
   int checks = 0;

   timer_alarm_scheduler #(
      .NUM_CH (NUM_CH),
      .ADDR_W (ADDR_W)
   ) dut (
      .hb_clk        (hb_clk),
      .hb_rst_n      (hb_rst_n),
      .mtime         (mtime),
      .waddr         (waddr),
      .wdata         (wdata),
      .wen           (wen),
      .raddr         (raddr),
      .ren           (ren),
      .rdata         (rdata),
      .alarm_int     (alarm_int),
      .alarm_pending (alarm_pending)
   );

   always #5 hb_clk = ~hb_clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge hb_clk);
   endtask

   task automatic wr(input int unsigned a, input logic [31:0] d);
      @(negedge hb_clk);
      waddr = ADDR_W'(a);
      wdata = d;
      wen   = 1'b1;
      @(negedge hb_clk);
      wen   = 1'b0;
   endtask

   task automatic rd_check(input string tag, input int unsigned a, input logic [31:0] exp);
      @(negedge hb_clk);
      raddr = ADDR_W'(a);
      ren   = 1'b1;
      @(negedge hb_clk);
      ren   = 1'b0;
      check(tag, 64'(rdata), 64'(exp));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      hb_rst_n = 1'b0;
      mtime    = '0;
      waddr    = '0;
      wdata    = '0;
      wen      = 1'b0;
      raddr    = '0;
      ren      = 1'b0;
      tick(3);
      hb_rst_n = 1'b1;

      // Reset state of every register and output.
      check("rst_int", 64'(alarm_int), 64'd0);
      check("rst_pending", 64'(alarm_pending), 64'd0);
      check("rst_rdata", 64'(rdata), 64'd0);
      for (int a = 0; a <= 18; a++) rd_check($sformatf("rst_rd%0d", a), a, 32'h0);
      rd_check("unmapped_rd19", 19, 32'h0);
      rd_check("unmapped_rd31", 31, 32'h0);
      wr(20, 32'hDEAD_BEEF);
      rd_check("unmapped_wr20", 20, 32'h0);
`ifndef ALARM_PERIODIC_EN
      wr(3, 32'h55);
      rd_check("period_unmapped", 3, 32'h0);
`endif

      // Two channels, ch1 earlier than ch2.
      wr(A_MASK, 32'hF);
      rd_check("mask_rd", A_MASK, 32'hF);
      wr(8, 100); wr(9, 0); wr(4, 50); wr(5, 0);
      wr(10, 1);  wr(6, 1);
      mtime = 64'd49;
      tick(10);
      check("ch1_before", 64'(alarm_pending), 64'h0);
      rd_check("status_armed_ch1", A_STAT, 32'h011);
      mtime = 64'd50;
      tick(1);
      check("ch1_fire", 64'(alarm_pending), 64'h2);
      check("int_lat1", 64'(alarm_int), 64'd0);
      tick(1);
      check("int_lat2", 64'(alarm_int), 64'd1);
      rd_check("ch1_en_cleared", 6, 32'h0);
      tick(8);
      mtime = 64'd99;
      tick(3);
      check("ch2_before", 64'(alarm_pending), 64'h2);
      mtime = 64'd100;
      tick(1);
      check("ch2_fire", 64'(alarm_pending), 64'h6);
      check("int_held", 64'(alarm_int), 64'd1);
      rd_check("ch2_en_cleared", 10, 32'h0);
      wr(A_PEND, 32'h6);
      check("w1c_all", 64'(alarm_pending), 64'h0);
      tick(1);
      check("int_drop", 64'(alarm_int), 64'd0);

      // Equal deadlines already in the past: ch0 then ch3 NUM_CH+1 cycles later.
      mtime = 64'd0;
      wr(0, 20); wr(1, 0); wr(12, 20); wr(13, 0);
      wr(2, 1);  wr(14, 1);
      tick(8);
      rd_check("status_tie_ch0", A_STAT, 32'h001);
      mtime = 64'd30;
      tick(1);
      check("tie_first", 64'(alarm_pending), 64'h1);
      tick(3);
      check("tie_gap4", 64'(alarm_pending), 64'h1);
      tick(1);
      raddr = ADDR_W'(A_STAT);
      ren   = 1'b1;
      check("tie_gap5", 64'(alarm_pending), 64'h1);
      tick(1);
      ren   = 1'b0;
      check("status_tie_ch3", 64'(rdata), 64'h031);
      check("tie_second", 64'(alarm_pending), 64'h9);
      wr(A_PEND, 32'h9);
      tick(2);

      // W1C on the same cycle ch1 fires: fire wins.
      mtime = 64'd0;
      wr(4, 40); wr(6, 1);
      tick(8);
      mtime = 64'd40;
      waddr = ADDR_W'(A_PEND);
      wdata = 32'h2;
      wen   = 1'b1;
      tick(1);
      wen   = 1'b0;
      check("w1c_vs_fire", 64'(alarm_pending), 64'h2);
      tick(1);
      check("w1c_int_high", 64'(alarm_int), 64'd1);
      wr(A_PEND, 32'h2);
      check("w1c_later", 64'(alarm_pending), 64'h0);
      check("w1c_int_still", 64'(alarm_int), 64'd1);
      tick(1);
      check("w1c_int_low", 64'(alarm_int), 64'd0);

      // Restart while armed on ch1 (500) by enabling ch0 (200).
      mtime = 64'd0;
      wr(4, 500); wr(6, 1);
      tick(8);
      rd_check("status_armed_500", A_STAT, 32'h011);
      wr(0, 200); wr(2, 1);
      tick(8);
      rd_check("status_rescan_ch0", A_STAT, 32'h001);
      mtime = 64'd199;
      tick(3);
      check("ch0_before", 64'(alarm_pending), 64'h0);
      mtime = 64'd200;
      tick(1);
      check("ch0_at200", 64'(alarm_pending), 64'h1);
      tick(8);
      mtime = 64'd499;
      tick(3);
      check("ch1_before500", 64'(alarm_pending), 64'h1);
      mtime = 64'd500;
      tick(1);
      check("ch1_at500", 64'(alarm_pending), 64'h3);
      wr(A_PEND, 32'hF);
      tick(8);
      rd_check("status_idle", A_STAT, 32'h000);

`ifdef ALARM_PERIODIC_EN
      // Periodic reload: 10, 35, 60, then one-shot once the period is 0.
      mtime = 64'd0;
      wr(0, 10); wr(1, 0); wr(3, 25); wr(2, 1);
      tick(8);
      mtime = 64'd10;
      tick(1);
      check("per_fire10", 64'(alarm_pending), 64'h1);
      wr(A_PEND, 32'h1);
      rd_check("per_dl35", 0, 32'd35);
      rd_check("per_en_kept", 2, 32'h1);
      tick(4);
      mtime = 64'd34;
      tick(3);
      check("per_before35", 64'(alarm_pending), 64'h0);
      mtime = 64'd35;
      tick(1);
      check("per_fire35", 64'(alarm_pending), 64'h1);
      wr(A_PEND, 32'h1);
      rd_check("per_dl60", 0, 32'd60);
      mtime = 64'd60;
      tick(1);
      check("per_fire60", 64'(alarm_pending), 64'h1);
      wr(A_PEND, 32'h1);
      wr(3, 0);
      tick(8);
      mtime = 64'd85;
      tick(1);
      check("oneshot_fire85", 64'(alarm_pending), 64'h1);
      rd_check("oneshot_en_clr", 2, 32'h0);
      rd_check("oneshot_dl85", 0, 32'd85);
      wr(A_PEND, 32'h1);
      tick(8);
`endif

      // Reset asserted mid-scan.
      mtime = 64'd0;
      wr(8, 1000);
      rd_check("pre_rst_rd", 8, 32'd1000);
      wr(10, 1);
      tick(1);
      hb_rst_n = 1'b0;
      #1;
      check("midscan_rdata", 64'(rdata), 64'd0);
      check("midscan_pending", 64'(alarm_pending), 64'h0);
      tick(1);
      hb_rst_n = 1'b1;
      rd_check("midscan_dl", 8, 32'h0);
      rd_check("midscan_ctrl", 10, 32'h0);
      rd_check("midscan_status", A_STAT, 32'h0);
      rd_check("midscan_mask", A_MASK, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/timer_alarm_scheduler.md
Name: timer_alarm_scheduler

Overview:
- Multiplexes NUM_CH software alarm channels onto the single 64-bit machine time count from the system timer.
- A scan FSM finds the earliest armed deadline. It then compares that deadline against mtime and raises a per-channel pending bit when the deadline is reached.
- Sits on the high-speed bus as a system peripheral, beside the system timer. Its interrupt feeds the platform interrupt controller.

Parameters:
- NUM_CH, 4, number of alarm channels (2..8).
- ADDR_W, 5, word-address width; must cover 4*NUM_CH+3 words.

Ports:
- hb_clk  in  1  high-speed bus clock; all logic in this domain.
- hb_rst_n  in  1  asynchronous active-low reset.
- mtime  in  64  current machine time from the system timer, same domain.
- waddr  in  ADDR_W  word write address.
- wdata  in  32  write data.
- wen  in  1  write strobe (block selected).
- raddr  in  ADDR_W  word read address.
- ren  in  1  read strobe (block selected).
- rdata  out  32  registered read data.
- alarm_int  out  1  level interrupt = |(pending & mask), registered.
- alarm_pending  out  NUM_CH  raw pending bits.

Behaviour:
- Register map:
  - Channel c, base 4c: +0 deadline_l, +1 deadline_h, +2 ctrl (bit0 en), +3 period (feature only; reads 0 otherwise).
  - Global, base 4*NUM_CH: +0 pending (W1C), +1 mask, +2 status {bit8 busy, bits6:4 best_idx, bit0 best_valid}.
  - Unmapped reads return 0; unmapped writes are ignored.
- Reset: all deadlines, ctrl, period, pending, mask, rdata, alarm_int = 0; FSM = IDLE.
- Reads: rdata updates on the cycle after ren (1-cycle latency) and holds otherwise.
- FSM states:
  - IDLE: best_valid=0. Go to SCAN on any write to ctrl/deadline/period, or whenever any en=1.
  - SCAN: idx steps 0..NUM_CH-1, one channel per cycle. An enabled channel replaces the best when no best exists yet or when its deadline < best (strictly less; ties go to the lowest index). After the last index: go to ARMED if a best exists, else IDLE. Scan takes NUM_CH cycles.
  - ARMED: each cycle, if mtime >= best_deadline (unsigned 64-bit), fire best_idx and go to SCAN.
- Fire action: pending[best_idx] <= 1 and en[best_idx] <= 0.
- Any write to any channel's deadline_l/deadline_h/ctrl/period while in SCAN or ARMED restarts SCAN at idx 0 on the next cycle. Software must clear en before changing the deadline words; non-atomic 64-bit updates are not protected.
- Deadline already in the past when armed: fires on the first ARMED cycle. Fire-to-pending latency is 1 cycle; fire-to-alarm_int latency is 2 cycles.
- Simultaneous W1C and fire on the same channel: the fire wins and pending stays 1.
- A fire and a restart-causing write in the same cycle are both applied; next state is SCAN.
- Only one channel fires per ARMED visit. Equal deadlines fire in consecutive passes, each pass separated by NUM_CH scan cycles.
- mtime wrap-around is not handled: deadlines are absolute unsigned values.
- Reset asserted mid-scan returns everything to reset values immediately.

Optional Feature:
- Macro: ALARM_PERIODIC_EN.
- Defined:
  - Per-channel 32-bit period register at +3.
  - On fire with period != 0: deadline <= deadline + zero-extended period (mod 2^64) and en stays 1.
  - period == 0 keeps one-shot behaviour.
  - A periodic channel whose new deadline is still <= mtime fires again after the rescan (catch-up).
- Undefined: no period storage, +3 reads 0, all channels one-shot.

Decomposition:
- Shared package: register offset constants (DEADLINE_L/H, CTRL, PERIOD, PENDING, MASK, STATUS), the FSM state enum, and the channel record typedef {deadline[63:0], en, period[31:0]}.
- One natural sub-module, alarm_min_scan: the scan/compare datapath (idx counter, best_idx, best_deadline, best_valid, done). The top level keeps the register file and FSM.

Test Plan:
- Reset, then read all registers: all 0, alarm_int=0, status=0.
- NUM_CH=4, mask=0xF. ch2 deadline=100, ch1 deadline=50, both en. mtime ramps from 0: pending=0b0010 at mtime 50; pending=0b0110 at mtime 100; alarm_int high 2 cycles after each fire.
- ch0 and ch3 both deadline=20, mtime=30: ch0 fires first; ch3 fires NUM_CH+1 cycles later; status best_idx observed as 0 then 3.
- W1C pending bit 1 in the same cycle ch1 fires: pending[1] remains 1. A later W1C clears it; alarm_int drops 1 cycle later.
- In ARMED on ch1 (deadline 500), write ch0 deadline=200 and en=1: FSM restarts SCAN; ch0 fires at mtime 200, ch1 at 500.
- ALARM_PERIODIC_EN: ch0 deadline=10, period=25: fires at mtime 10, 35, 60; en stays 1. With period=0, fires once and en reads 0.
